lsu_mem_access: RTL and testbench
=================================

# lsu_mem_access

Load/store unit for the RISC-V core. It sits directly downstream of the ALU and consumes the ALU result `C` as the effective address for loads and stores. It runs a request/acknowledge transaction on the data-memory port, handles byte-lane selection and store-data replication, and returns a sign- or zero-extended load result to writeback. It stalls the core through `busy` until the access completes.

## Interface
- `TIMEOUT_CYC`, default 255: maximum number of cycles `mem_req` stays high without `mem_ack` before the access is aborted with an error. Legal range is 1..65535.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: execute stage holds a load or store. Sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load. Sampled with `start`.
- `funct3` in 3: access type. LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- `addr` in 32: effective address, equal to the ALU `C` output.
- `wdata` in 32: store data (rs2).
- `busy` out 1: stall request to the PC and register file.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: misaligned, illegal or timed-out access. Valid only while `done` is high.
- `rdata` out 32: extended load result. Held until the next load completes.
- `mem_req` out 1: memory request. Registered.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory completion. Sampled only in REQ.
- `mem_rdata` in 32: read word. Valid while `mem_ack` is high.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with `start`=1: latch `is_store`, `funct3`, `addr` and `wdata`, then check the access.
  - Illegal access: `funct3` is 011, 110 or 111, or a store with `funct3[2]`=1.
  - Misaligned access: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal or misaligned → go to DONE with the error flag set. `mem_req` is never raised.
  - Otherwise → go to REQ.
- REQ:
  - `mem_req`=1 with `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stable for the whole state.
  - `mem_ack`=1 → go to DONE. On a load, capture the extended result into `rdata` on that edge.
  - No ack after `TIMEOUT_CYC` REQ cycles → go to DONE with the error flag set.
- DONE: `done`=1 for one cycle, `err` = the latched error flag, then return to IDLE.
- Byte enables (`mem_be`):
  - Byte access: `4'b0001 << addr[1:0]`.
  - Halfword access: `addr[1] ? 4'b1100 : 4'b0011`.
  - Word access: `4'b1111`.
  - Loads drive the same enables with `mem_we`=0.
- Store data (`mem_wdata`): byte `{4{wdata[7:0]}}`, halfword `{2{wdata[15:0]}}`, word `wdata`.
- Load data: select the byte or halfword lane of `mem_rdata` by `addr[1:0]`.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through unchanged.
- Stores, errors and timeouts leave `rdata` unchanged.
- `start` in REQ or DONE is ignored.
- `mem_ack` in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, timeout counter=0.
- Reset mid-operation: `mem_req` drops immediately (asynchronous). There is no completion pulse, and the partial transaction is abandoned.
- `busy` = (IDLE & `start`) | REQ. It is combinational in the accept cycle and low in DONE, so the core advances on the DONE edge.
- Latency from the accept edge:
  - `mem_req` rises 1 cycle after `start` is sampled.
  - An ack in the first REQ cycle gives `done` 2 cycles after `start`, the minimum.
  - An ack k cycles into REQ gives `done` at k+1.
  - An error path gives `done` 1 cycle after `start`, with no request.
- Timeout counter:
  - Cleared on entering REQ; increments each REQ cycle without ack.
  - `mem_req` stays high for exactly `TIMEOUT_CYC` cycles on timeout.
  - An ack on the final cycle wins: no error.
- Back-to-back accesses: `start` held high through DONE is re-accepted in the following IDLE cycle. The throughput is at most one access per 3 cycles.

## Test plan
- SW: addr=0x100, wdata=0xDEADBEEF, ack in the first REQ cycle → `mem_be`=1111, `mem_we`=1, `mem_wdata`=0xDEADBEEF; `done` 2 cycles after `start`, `err`=0.
- SB: addr=0x103, wdata=0x000000A5 → `mem_addr`=0x100, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LB and LBU: addr=0x202, `mem_rdata`=0x12F45678 with 3-cycle ack delay → `rdata`=0xFFFFFFF4 (LB) or 0x000000F4 (LBU); `done` 4 cycles after `start`.
- LH: addr=0x301 → `done` after 1 cycle with `err`=1, `mem_req` never high, `rdata` unchanged.
- LW with `TIMEOUT_CYC`=4 and no ack → `mem_req` high exactly 4 cycles, then `done` with `err`=1. Repeat with the ack on the 4th cycle → `err`=0.
- Assert `reset` during REQ → `mem_req` low in the same cycle, state IDLE, no `done`. The next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - load/store unit: request/ack data-memory access with lane select and extension
// Accepts one access from execute, checks alignment/legality, runs the memory handshake, returns the load result.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      r_state, w_next;
  logic        r_is_store, r_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_accept, w_illegal, w_misalign, w_bad, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_load;
  logic [15:0] w_half;

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_illegal  = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) || (i_is_store && i_funct3[2]);
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_bad      = w_illegal || w_misalign;
  assign w_timeout  = (r_cnt == LP_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the address latched at accept, so it is stable through REQ.
  assign w_shift = i_mem_rdata >> {r_lane, 3'b000};
  assign w_half  = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    w_load = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    o_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          o_busy = 1'b1;
          w_next = w_bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        o_busy = 1'b1;
        if (i_mem_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_is_store  <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_cnt       <= 16'd0;
      r_rdata     <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
    end else if (w_accept) begin
      r_is_store  <= i_is_store;
      r_err       <= w_bad;
      r_funct3    <= i_funct3;
      r_lane      <= i_addr[1:0];
      r_cnt       <= 16'd0;
      r_mem_req   <= !w_bad;
      r_mem_we    <= i_is_store;
      r_mem_addr  <= {i_addr[31:2], 2'b00};
      r_mem_be    <= w_be;
      r_mem_wdata <= w_wdata;
    end else if (r_state == S_REQ) begin
      // An ack on the last allowed cycle takes priority over the timeout.
      if (i_mem_ack) begin
        r_mem_req <= 1'b0;
        if (!r_is_store) r_rdata <= w_load;
      end else if (w_timeout) begin
        r_mem_req <= 1'b0;
        r_err     <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - scoreboard bench for lsu_mem_access
// Stimulus pushes expected completions; a negedge monitor pops them on each done pulse.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst, start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'd0;

  lsu_mem_access #(.TIMEOUT_CYC(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_is_store(is_store),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_err", {31'd0, err}, {31'd0, e.err});
        chk("done_rdata", rdata, e.rdata);
      end
    end
  end

  // k = REQ cycle on which mem_ack is driven (0 = never); new_rd = load result if it succeeds.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int k, input logic [31:0] rd, input logic exp_err,
                        input int exp_lat, input int exp_req, input logic [3:0] exp_be,
                        input logic [31:0] exp_maddr, input logic [31:0] exp_wd, input logic [31:0] new_rd);
    int   n, nreq;
    logic got;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    if (!st && !exp_err) model_rdata = new_rd;
    q.push_back('{err: exp_err, rdata: model_rdata});
    #1 chk("busy_accept", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1; nreq = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++;
        chk("req_we", {31'd0, mem_we}, {31'd0, st});
        chk("req_addr", mem_addr, exp_maddr);
        chk("req_be", {28'd0, mem_be}, {28'd0, exp_be});
        if (st) chk("req_wdata", mem_wdata, exp_wd);
        mem_ack   = (nreq == k);
        mem_rdata = rd;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
      n++;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", n, exp_lat);
      chk("req_cycles", nreq, exp_req);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    //     st f3      addr          wdata          k  mem_rdata     err lat req be       maddr         wdata          new rdata
    access(1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 1, 32'h0,        0,  2,  1,  4'b1111, 32'h0000_0100, 32'hDEADBEEF, 32'h0);
    access(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0,       0,  2,  1,  4'b1000, 32'h0000_0100, 32'hA5A5A5A5, 32'h0);
    access(1, 3'b001, 32'h0000_0102, 32'h1234ABCD, 1, 32'h0,        0,  2,  1,  4'b1100, 32'h0000_0100, 32'hABCDABCD, 32'h0);
    access(0, 3'b000, 32'h0000_0202, 32'h0,        3, 32'h12F45678, 0,  4,  3,  4'b0100, 32'h0000_0200, 32'h0,        32'hFFFFFFF4);
    access(0, 3'b100, 32'h0000_0202, 32'h0,        3, 32'h12F45678, 0,  4,  3,  4'b0100, 32'h0000_0200, 32'h0,        32'h000000F4);
    access(0, 3'b001, 32'h0000_0206, 32'h0,        2, 32'h80017FFF, 0,  3,  2,  4'b1100, 32'h0000_0204, 32'h0,        32'hFFFF8001);
    access(0, 3'b101, 32'h0000_0204, 32'h0,        1, 32'h80017FFF, 0,  2,  1,  4'b0011, 32'h0000_0204, 32'h0,        32'h00007FFF);
    access(0, 3'b001, 32'h0000_0301, 32'h0,        1, 32'h0,        1,  1,  0,  4'b0000, 32'h0,         32'h0,        32'h0);
    access(0, 3'b011, 32'h0000_0000, 32'h0,        1, 32'h0,        1,  1,  0,  4'b0000, 32'h0,         32'h0,        32'h0);
    access(1, 3'b100, 32'h0000_0000, 32'h0,        1, 32'h0,        1,  1,  0,  4'b0000, 32'h0,         32'h0,        32'h0);
    access(0, 3'b010, 32'h0000_0402, 32'h0,        1, 32'h0,        1,  1,  0,  4'b0000, 32'h0,         32'h0,        32'h0);
    access(0, 3'b010, 32'h0000_0400, 32'h0,        0, 32'h0,        1,  5,  4,  4'b1111, 32'h0000_0400, 32'h0,        32'h0);
    access(0, 3'b010, 32'h0000_0400, 32'h0,        4, 32'hCAFEF00D, 0,  5,  4,  4'b1111, 32'h0000_0400, 32'h0,        32'hCAFEF00D);

    // Reset in the middle of a request: mem_req drops at once, no completion.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mid_req_high", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rst_busy_drop", {31'd0, busy}, 32'd0);
    chk("rst_no_done", {31'd0, done}, 32'd0);
    model_rdata = 32'd0;
    @(negedge clk);
    chk("rst_rdata_clear", rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    access(0, 3'b010, 32'h0000_0010, 32'h0,        2, 32'h11223344, 0,  3,  2,  4'b1111, 32'h0000_0010, 32'h0,        32'h11223344);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
